// File: rtl/punc_ctrl_pkg.sv
// Shared encodings for the PUnC control path: opcodes, FSM states, datapath
// select values and the packed control word driven by punc_control.
package punc_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LD   = 4'b0010,
    OP_ST   = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_RSV  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_EXECUTE2,
    ST_HALT
  } state_e;

  typedef enum logic [1:0] {
    MEM_W_ADDR_PC_OFF9   = 2'd0,
    MEM_W_ADDR_BASE_OFF6 = 2'd1,
    MEM_W_ADDR_MEM_DATA  = 2'd2
  } mem_w_addr_sel_e;

  typedef enum logic {
    MEM_W_DATA_RF_R0    = 1'b0,
    MEM_W_DATA_MEM_DATA = 1'b1
  } mem_w_data_sel_e;

  typedef enum logic [1:0] {
    MEM_R_ADDR_PC        = 2'd0,
    MEM_R_ADDR_PC_OFF9   = 2'd1,
    MEM_R_ADDR_BASE_OFF6 = 2'd2,
    MEM_R_ADDR_LDI_TEMP  = 2'd3
  } mem_r_addr_sel_e;

  typedef enum logic {
    RF_R0_ADDR_IR_8_6  = 1'b0,
    RF_R0_ADDR_IR_11_9 = 1'b1
  } rf_r0_addr_sel_e;

  typedef enum logic {
    RF_R1_ADDR_IR_2_0 = 1'b0,
    RF_R1_ADDR_IR_8_6 = 1'b1
  } rf_r1_addr_sel_e;

  typedef enum logic [1:0] {
    RF_W_DATA_ALU     = 2'd0,
    RF_W_DATA_MEM     = 2'd1,
    RF_W_DATA_PC      = 2'd2,
    RF_W_DATA_PC_OFF9 = 2'd3
  } rf_w_data_sel_e;

  typedef enum logic {
    RF_W_ADDR_IR_11_9 = 1'b0,
    RF_W_ADDR_R7      = 1'b1
  } rf_w_addr_sel_e;

  typedef enum logic [1:0] {
    PC_LD_PC_OFF9  = 2'd0,
    PC_LD_RF_R0    = 2'd1,
    PC_LD_PC_OFF11 = 2'd2
  } pc_ld_data_sel_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_ADDI = 3'd1,
    ALU_NOT  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_ANDI = 3'd4,
    ALU_PASS = 3'd5
  } alu_sel_e;

  typedef enum logic {
    COND_LD_ALU     = 1'b0,
    COND_LD_RF_DATA = 1'b1
  } cond_ld_data_sel_e;

  typedef struct packed {
    logic              mem_w_en;
    mem_w_addr_sel_e   mem_w_addr_sel;
    mem_w_data_sel_e   mem_w_data_sel;
    mem_r_addr_sel_e   mem_r_addr_sel;
    logic              rf_w_en;
    rf_r0_addr_sel_e   rf_r0_addr_sel;
    rf_r1_addr_sel_e   rf_r1_addr_sel;
    rf_w_data_sel_e    rf_w_data_sel;
    rf_w_addr_sel_e    rf_w_addr_sel;
    logic              ir_ld;
    logic              pc_ld;
    logic              pc_clr;
    logic              pc_inc;
    pc_ld_data_sel_e   pc_ld_data_sel;
    alu_sel_e          alu_sel;
    logic              cond_ld;
    cond_ld_data_sel_e cond_ld_data_sel;
    logic              ldi_reg_ld;
    logic              halted;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic opcode_e ir_opcode(input logic [15:0] ir_word);
    return opcode_e'(ir_word[15:12]);
  endfunction

endpackage

// File: rtl/punc_branch_eval.sv
// Combinational BR condition check: taken when any nzp bit in the instruction
// matches the current condition code; nzp=000 never branches.
module punc_branch_eval (
  input  logic [2:0] nzp_i,
  input  logic       n_i,
  input  logic       z_i,
  input  logic       p_i,
  output logic       taken_o
);

  assign taken_o = |(nzp_i & {n_i, z_i, p_i});

endmodule

// File: rtl/punc_control.sv
// Moore control FSM for the PUnC LC3 datapath: 3 cycles per instruction, 4 for LDI/STI; no flow control.
// `define PUNC_CTRL_ILLEGAL_TRAP_EN turns opcodes 1000/1101 into a halt with a sticky `illegal` flag.
module punc_control
  import punc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  output logic        mem_w_en,
  output logic [1:0]  mem_w_addr_sel,
  output logic        mem_w_data_sel,
  output logic [1:0]  mem_r_addr_sel,
  output logic        rf_w_en,
  output logic        rf_r0_addr_sel,
  output logic        rf_r1_addr_sel,
  output logic [1:0]  rf_w_data_sel,
  output logic        rf_w_addr_sel,
  output logic        ir_ld,
  output logic        pc_ld,
  output logic        pc_clr,
  output logic        pc_inc,
  output logic [1:0]  pc_ld_data_sel,
  output logic [2:0]  alu_sel,
  output logic        cond_ld,
  output logic        cond_ld_data_sel,
  output logic        ldi_reg_ld,
  output logic        halted
`ifdef PUNC_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic        illegal
`endif
);

  state_e  state_q, state_d;
  ctrl_t   ctrl;
  opcode_e opcode;
  logic    br_taken;
  logic    unused_ir;

  assign opcode    = ir_opcode(ir);
  assign unused_ir = ^{ir[8:6], ir[4:0]};

  punc_branch_eval u_branch_eval (
    .nzp_i   (ir[11:9]),
    .n_i     (n),
    .z_i     (z),
    .p_i     (p),
    .taken_o (br_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef PUNC_CTRL_ILLEGAL_TRAP_EN
  logic illegal_set;
  logic illegal_q, illegal_d;

  assign illegal_d = illegal_q | illegal_set;
  assign illegal   = illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    ctrl    = CTRL_IDLE;
`ifdef PUNC_CTRL_ILLEGAL_TRAP_EN
    illegal_set = 1'b0;
`endif
    // Reset overrides the state decode so no strobe leaks out mid-instruction.
    if (rst) begin
      ctrl.pc_clr = 1'b1;
      state_d     = ST_INIT;
    end else begin
      case (state_q)
        ST_INIT: begin
          ctrl.pc_clr = 1'b1;
          state_d     = ST_FETCH;
        end
        ST_FETCH: begin
          ctrl.mem_r_addr_sel = MEM_R_ADDR_PC;
          ctrl.ir_ld          = 1'b1;
          ctrl.pc_inc         = 1'b1;
          state_d             = ST_DECODE;
        end
        ST_DECODE: begin
          state_d = ST_EXECUTE;
        end
        ST_EXECUTE: begin
          state_d = ST_FETCH;
          case (opcode)
            OP_ADD, OP_AND: begin
              if (opcode == OP_ADD) begin
                ctrl.alu_sel = ir[5] ? ALU_ADDI : ALU_ADD;
              end else begin
                ctrl.alu_sel = ir[5] ? ALU_ANDI : ALU_AND;
              end
              ctrl.rf_w_en = 1'b1;
              ctrl.cond_ld = 1'b1;
            end
            OP_NOT: begin
              ctrl.alu_sel = ALU_NOT;
              ctrl.rf_w_en = 1'b1;
              ctrl.cond_ld = 1'b1;
            end
            OP_BR: begin
              ctrl.pc_ld          = br_taken;
              ctrl.pc_ld_data_sel = PC_LD_PC_OFF9;
            end
            OP_JMP: begin
              ctrl.pc_ld          = 1'b1;
              ctrl.pc_ld_data_sel = PC_LD_RF_R0;
              ctrl.rf_r0_addr_sel = RF_R0_ADDR_IR_8_6;
            end
            OP_JSR: begin
              // Link write sees the pre-update PC since both land on the same edge.
              ctrl.rf_w_en        = 1'b1;
              ctrl.rf_w_addr_sel  = RF_W_ADDR_R7;
              ctrl.rf_w_data_sel  = RF_W_DATA_PC;
              ctrl.pc_ld          = 1'b1;
              ctrl.pc_ld_data_sel = ir[11] ? PC_LD_PC_OFF11 : PC_LD_RF_R0;
              ctrl.rf_r0_addr_sel = RF_R0_ADDR_IR_8_6;
            end
            OP_LD, OP_LDR: begin
              ctrl.mem_r_addr_sel   = (opcode == OP_LD) ? MEM_R_ADDR_PC_OFF9
                                                        : MEM_R_ADDR_BASE_OFF6;
              ctrl.rf_w_en          = 1'b1;
              ctrl.rf_w_data_sel    = RF_W_DATA_MEM;
              ctrl.cond_ld          = 1'b1;
              ctrl.cond_ld_data_sel = COND_LD_RF_DATA;
            end
            OP_LEA: begin
              ctrl.rf_w_en          = 1'b1;
              ctrl.rf_w_data_sel    = RF_W_DATA_PC_OFF9;
              ctrl.cond_ld          = 1'b1;
              ctrl.cond_ld_data_sel = COND_LD_RF_DATA;
            end
            OP_ST: begin
              ctrl.mem_w_en       = 1'b1;
              ctrl.mem_w_addr_sel = MEM_W_ADDR_PC_OFF9;
              ctrl.mem_w_data_sel = MEM_W_DATA_RF_R0;
              ctrl.rf_r0_addr_sel = RF_R0_ADDR_IR_11_9;
            end
            OP_STR: begin
              ctrl.mem_w_en       = 1'b1;
              ctrl.mem_w_addr_sel = MEM_W_ADDR_BASE_OFF6;
              ctrl.mem_w_data_sel = MEM_W_DATA_RF_R0;
              ctrl.rf_r0_addr_sel = RF_R0_ADDR_IR_11_9;
              ctrl.rf_r1_addr_sel = RF_R1_ADDR_IR_8_6;
            end
            OP_LDI, OP_STI: begin
              ctrl.mem_r_addr_sel = MEM_R_ADDR_PC_OFF9;
              ctrl.ldi_reg_ld     = 1'b1;
              state_d             = ST_EXECUTE2;
            end
            OP_TRAP: begin
              state_d = ST_HALT;
            end
            OP_RTI, OP_RSV: begin
`ifdef PUNC_CTRL_ILLEGAL_TRAP_EN
              illegal_set = 1'b1;
              state_d     = ST_HALT;
`endif
            end
          endcase
        end
        ST_EXECUTE2: begin
          state_d             = ST_FETCH;
          ctrl.mem_r_addr_sel = MEM_R_ADDR_LDI_TEMP;
          if (opcode == OP_LDI) begin
            ctrl.rf_w_en          = 1'b1;
            ctrl.rf_w_data_sel    = RF_W_DATA_MEM;
            ctrl.cond_ld          = 1'b1;
            ctrl.cond_ld_data_sel = COND_LD_RF_DATA;
          end else begin
            ctrl.mem_w_en       = 1'b1;
            ctrl.mem_w_addr_sel = MEM_W_ADDR_MEM_DATA;
            ctrl.mem_w_data_sel = MEM_W_DATA_RF_R0;
            ctrl.rf_r0_addr_sel = RF_R0_ADDR_IR_11_9;
          end
        end
        ST_HALT: begin
          ctrl.halted = 1'b1;
        end
        default: begin
          state_d = ST_INIT;
        end
      endcase
    end
  end

  assign mem_w_en         = ctrl.mem_w_en;
  assign mem_w_addr_sel   = ctrl.mem_w_addr_sel;
  assign mem_w_data_sel   = ctrl.mem_w_data_sel;
  assign mem_r_addr_sel   = ctrl.mem_r_addr_sel;
  assign rf_w_en          = ctrl.rf_w_en;
  assign rf_r0_addr_sel   = ctrl.rf_r0_addr_sel;
  assign rf_r1_addr_sel   = ctrl.rf_r1_addr_sel;
  assign rf_w_data_sel    = ctrl.rf_w_data_sel;
  assign rf_w_addr_sel    = ctrl.rf_w_addr_sel;
  assign ir_ld            = ctrl.ir_ld;
  assign pc_ld            = ctrl.pc_ld;
  assign pc_clr           = ctrl.pc_clr;
  assign pc_inc           = ctrl.pc_inc;
  assign pc_ld_data_sel   = ctrl.pc_ld_data_sel;
  assign alu_sel          = ctrl.alu_sel;
  assign cond_ld          = ctrl.cond_ld;
  assign cond_ld_data_sel = ctrl.cond_ld_data_sel;
  assign ldi_reg_ld       = ctrl.ldi_reg_ld;
  assign halted           = ctrl.halted;

endmodule

// File: tb/tb_punc_control.sv
// Bench for punc_control: constant vector table, reset/halt sequences and a
// randomized instruction stream checked against a rule-based control model.
module tb_punc_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ir  = 16'h0000;
  logic        n = 1'b0, z = 1'b0, p = 1'b0;
  logic        mem_w_en, mem_w_data_sel, rf_w_en, rf_r0_addr_sel, rf_r1_addr_sel;
  logic        rf_w_addr_sel, ir_ld, pc_ld, pc_clr, pc_inc, cond_ld;
  logic        cond_ld_data_sel, ldi_reg_ld, halted;
  logic [1:0]  mem_w_addr_sel, mem_r_addr_sel, rf_w_data_sel, pc_ld_data_sel;
  logic [2:0]  alu_sel;
`ifdef PUNC_CTRL_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  always #5 clk = ~clk;

  punc_control dut (
    .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p),
    .mem_w_en(mem_w_en), .mem_w_addr_sel(mem_w_addr_sel), .mem_w_data_sel(mem_w_data_sel),
    .mem_r_addr_sel(mem_r_addr_sel), .rf_w_en(rf_w_en), .rf_r0_addr_sel(rf_r0_addr_sel),
    .rf_r1_addr_sel(rf_r1_addr_sel), .rf_w_data_sel(rf_w_data_sel), .rf_w_addr_sel(rf_w_addr_sel),
    .ir_ld(ir_ld), .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_inc(pc_inc),
    .pc_ld_data_sel(pc_ld_data_sel), .alu_sel(alu_sel), .cond_ld(cond_ld),
    .cond_ld_data_sel(cond_ld_data_sel), .ldi_reg_ld(ldi_reg_ld), .halted(halted)
`ifdef PUNC_CTRL_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  typedef struct packed {
    logic       mem_w_en;
    logic [1:0] mem_w_addr_sel;
    logic       mem_w_data_sel;
    logic [1:0] mem_r_addr_sel;
    logic       rf_w_en;
    logic       rf_r0_addr_sel;
    logic       rf_r1_addr_sel;
    logic [1:0] rf_w_data_sel;
    logic       rf_w_addr_sel;
    logic       ir_ld;
    logic       pc_ld;
    logic       pc_clr;
    logic       pc_inc;
    logic [1:0] pc_ld_data_sel;
    logic [2:0] alu_sel;
    logic       cond_ld;
    logic       cond_ld_data_sel;
    logic       ldi_reg_ld;
    logic       halted;
  } ctl_t;

  typedef struct {
    string       name;
    logic [15:0] ir;
    logic [2:0]  nzp;
    logic        two;
    ctl_t        ex1;
    ctl_t        ex2;
  } vec_t;

  localparam ctl_t C_IDLE  = '0;
  localparam ctl_t C_INIT  = ctl_t'{pc_clr: 1'b1, default: '0};
  localparam ctl_t C_FETCH = ctl_t'{ir_ld: 1'b1, pc_inc: 1'b1, default: '0};
  localparam ctl_t C_HALT  = ctl_t'{halted: 1'b1, default: '0};

  ctl_t act;
  assign act = {mem_w_en, mem_w_addr_sel, mem_w_data_sel, mem_r_addr_sel, rf_w_en,
                rf_r0_addr_sel, rf_r1_addr_sel, rf_w_data_sel, rf_w_addr_sel, ir_ld,
                pc_ld, pc_clr, pc_inc, pc_ld_data_sel, alu_sel, cond_ld,
                cond_ld_data_sel, ldi_reg_ld, halted};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input ctl_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Reference: what the datapath must see in each phase of one instruction.
  // phase 0 fetch, 1 decode, 2 execute, 3 second execute (LDI/STI only).
  function automatic ctl_t model(input int phase, input logic [15:0] w, input logic [2:0] nzp);
    ctl_t e = '0;
    int   op = int'(w[15:12]);
    logic taken = ((w[11] & nzp[2]) | (w[10] & nzp[1]) | (w[9] & nzp[0]));
    if (phase == 0) return C_FETCH;
    if (phase == 1) return C_IDLE;
    if (phase == 3) begin
      e.mem_r_addr_sel = 2'd3;
      if (op == 10) begin
        e.rf_w_en = 1'b1; e.rf_w_data_sel = 2'd1; e.cond_ld = 1'b1; e.cond_ld_data_sel = 1'b1;
      end else begin
        e.mem_w_en = 1'b1; e.mem_w_addr_sel = 2'd2; e.rf_r0_addr_sel = 1'b1;
      end
      return e;
    end
    e.rf_w_en          = op inside {1, 5, 9, 2, 6, 14, 4};
    e.cond_ld          = op inside {1, 5, 9, 2, 6, 14};
    e.cond_ld_data_sel = op inside {2, 6, 14};
    e.alu_sel          = (op == 1) ? (w[5] ? 3'd1 : 3'd0) :
                         (op == 5) ? (w[5] ? 3'd4 : 3'd3) :
                         (op == 9) ? 3'd2 : 3'd0;
    e.rf_w_data_sel    = (op inside {2, 6}) ? 2'd1 : (op == 4) ? 2'd2 : (op == 14) ? 2'd3 : 2'd0;
    e.rf_w_addr_sel    = (op == 4);
    e.mem_r_addr_sel   = (op inside {2, 10, 11}) ? 2'd1 : (op == 6) ? 2'd2 : 2'd0;
    e.mem_w_en         = op inside {3, 7};
    e.mem_w_addr_sel   = (op == 7) ? 2'd1 : 2'd0;
    e.rf_r0_addr_sel   = op inside {3, 7};
    e.rf_r1_addr_sel   = (op == 7);
    e.pc_ld            = (op == 12) || (op == 4) || (op == 0 && taken);
    e.pc_ld_data_sel   = (op == 12) ? 2'd1 : (op == 4) ? (w[11] ? 2'd2 : 2'd1) : 2'd0;
    e.ldi_reg_ld       = op inside {10, 11};
    return e;
  endfunction

  // Entered just after the edge that starts FETCH; returns just after the next FETCH edge.
  task automatic run_vec(input vec_t v);
    ir = v.ir; {n, z, p} = v.nzp;
    #1 check({v.name, "_fetch"}, C_FETCH);
    cyc(); #1 check({v.name, "_decode"}, C_IDLE);
    cyc(); #1 check({v.name, "_exec"}, v.ex1);
    if (v.two) begin
      cyc(); #1 check({v.name, "_exec2"}, v.ex2);
    end
    cyc();
  endtask

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vecs.push_back('{"add",   16'h1283, 3'b000, 1'b0, ctl_t'{rf_w_en: 1, cond_ld: 1, default: 0}, C_IDLE});
    vecs.push_back('{"addi",  16'h1265, 3'b000, 1'b0, ctl_t'{rf_w_en: 1, cond_ld: 1, alu_sel: 1, default: 0}, C_IDLE});
    vecs.push_back('{"and",   16'h5283, 3'b000, 1'b0, ctl_t'{rf_w_en: 1, cond_ld: 1, alu_sel: 3, default: 0}, C_IDLE});
    vecs.push_back('{"andi",  16'h5260, 3'b000, 1'b0, ctl_t'{rf_w_en: 1, cond_ld: 1, alu_sel: 4, default: 0}, C_IDLE});
    vecs.push_back('{"not",   16'h927F, 3'b000, 1'b0, ctl_t'{rf_w_en: 1, cond_ld: 1, alu_sel: 2, default: 0}, C_IDLE});
    vecs.push_back('{"brz_t", 16'h0405, 3'b010, 1'b0, ctl_t'{pc_ld: 1, default: 0}, C_IDLE});
    vecs.push_back('{"brz_nt",16'h0405, 3'b001, 1'b0, C_IDLE, C_IDLE});
    vecs.push_back('{"br000", 16'h0005, 3'b111, 1'b0, C_IDLE, C_IDLE});
    vecs.push_back('{"brnzp", 16'h0E05, 3'b100, 1'b0, ctl_t'{pc_ld: 1, default: 0}, C_IDLE});
    vecs.push_back('{"jmp",   16'hC1C0, 3'b000, 1'b0, ctl_t'{pc_ld: 1, pc_ld_data_sel: 1, default: 0}, C_IDLE});
    vecs.push_back('{"jsr",   16'h4802, 3'b000, 1'b0, ctl_t'{rf_w_en: 1, rf_w_addr_sel: 1, rf_w_data_sel: 2,
                                                              pc_ld: 1, pc_ld_data_sel: 2, default: 0}, C_IDLE});
    vecs.push_back('{"jsrr",  16'h4080, 3'b000, 1'b0, ctl_t'{rf_w_en: 1, rf_w_addr_sel: 1, rf_w_data_sel: 2,
                                                              pc_ld: 1, pc_ld_data_sel: 1, default: 0}, C_IDLE});
    vecs.push_back('{"ld",    16'h2205, 3'b000, 1'b0, ctl_t'{mem_r_addr_sel: 1, rf_w_en: 1, rf_w_data_sel: 1,
                                                              cond_ld: 1, cond_ld_data_sel: 1, default: 0}, C_IDLE});
    vecs.push_back('{"ldr",   16'h6283, 3'b000, 1'b0, ctl_t'{mem_r_addr_sel: 2, rf_w_en: 1, rf_w_data_sel: 1,
                                                              cond_ld: 1, cond_ld_data_sel: 1, default: 0}, C_IDLE});
    vecs.push_back('{"lea",   16'hE205, 3'b000, 1'b0, ctl_t'{rf_w_en: 1, rf_w_data_sel: 3, cond_ld: 1,
                                                              cond_ld_data_sel: 1, default: 0}, C_IDLE});
    vecs.push_back('{"st",    16'h3205, 3'b000, 1'b0, ctl_t'{mem_w_en: 1, rf_r0_addr_sel: 1, default: 0}, C_IDLE});
    vecs.push_back('{"str",   16'h7283, 3'b000, 1'b0, ctl_t'{mem_w_en: 1, mem_w_addr_sel: 1, rf_r0_addr_sel: 1,
                                                              rf_r1_addr_sel: 1, default: 0}, C_IDLE});
    vecs.push_back('{"ldi",   16'hA203, 3'b000, 1'b1, ctl_t'{mem_r_addr_sel: 1, ldi_reg_ld: 1, default: 0},
                     ctl_t'{mem_r_addr_sel: 3, rf_w_en: 1, rf_w_data_sel: 1, cond_ld: 1, cond_ld_data_sel: 1, default: 0}});
    vecs.push_back('{"sti",   16'hB203, 3'b000, 1'b1, ctl_t'{mem_r_addr_sel: 1, ldi_reg_ld: 1, default: 0},
                     ctl_t'{mem_w_en: 1, mem_w_addr_sel: 2, mem_r_addr_sel: 3, rf_r0_addr_sel: 1, default: 0}});
`ifndef PUNC_CTRL_ILLEGAL_TRAP_EN
    vecs.push_back('{"nop8",  16'h8000, 3'b000, 1'b0, C_IDLE, C_IDLE});
    vecs.push_back('{"nopD",  16'hD123, 3'b111, 1'b0, C_IDLE, C_IDLE});
`endif

    // Reset held two cycles, then INIT, then FETCH.
    cyc(); #1 check("rst_0", C_INIT);
    cyc(); #1 check("rst_1", C_INIT);
    rst = 1'b0;
    #1 check("init", C_INIT);
    cyc();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Randomized stream with occasional reset at an arbitrary phase.
    for (int k = 0; k < 300; k++) begin
      logic [15:0] w;
      logic [2:0]  nzp;
      int          phases, rphase;
      w   = 16'($urandom);
      nzp = 3'($urandom);
      if (w[15:12] inside {4'h8, 4'hD, 4'hF}) w[15:12] = 4'h1;
      phases = (w[15:12] inside {4'hA, 4'hB}) ? 4 : 3;
      rphase = ($urandom_range(9) == 0) ? int'($urandom_range(phases - 1)) : -1;
      ir = w; {n, z, p} = nzp;
      for (int ph = 0; ph < phases; ph++) begin
        if (ph == rphase) begin
          rst = 1'b1;
          #1 check("rand_rst", C_INIT);
          cyc(); rst = 1'b0;
          #1 check("rand_rst_init", C_INIT);
          break;
        end
        #1 check($sformatf("rand_%04h_ph%0d", w, ph), model(ph, w, nzp));
        if (ph < phases - 1) cyc();
      end
      cyc();
    end

    // TRAP: halted held with no strobes regardless of inputs, released by reset.
    ir = 16'hF025; {n, z, p} = 3'b000;
    #1 check("trap_fetch", C_FETCH);
    cyc(); #1 check("trap_decode", C_IDLE);
    cyc(); #1 check("trap_exec", C_IDLE);
    for (int c = 0; c < 20; c++) begin
      cyc();
      ir = 16'($urandom); {n, z, p} = 3'($urandom);
      #1 check($sformatf("halt_%0d", c), C_HALT);
    end
    rst = 1'b1;
    #1 check("halt_rst", C_INIT);
    cyc(); rst = 1'b0;
    #1 check("halt_rst_init", C_INIT);
    check_bit("halt_rst_halted", halted, 1'b0);
    cyc(); #1 check("halt_rst_fetch", C_FETCH);

`ifdef PUNC_CTRL_ILLEGAL_TRAP_EN
    ir = 16'h8000;
    check_bit("illegal_before", illegal, 1'b0);
    cyc(); cyc(); cyc();
    #1 check("illegal_halt", C_HALT);
    check_bit("illegal_set", illegal, 1'b1);
    cyc(); #1 check_bit("illegal_sticky", illegal, 1'b1);
    rst = 1'b1;
    cyc(); rst = 1'b0;
    #1 check_bit("illegal_clr", illegal, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/punc_control.md
Name: punc_control

Overview:
Moore-style control FSM that sequences the PUnC LC3 datapath: fetch, decode, execute (plus a second execute cycle for LDI/STI), and halt.
- Consumes the instruction register and n/z/p condition codes from the datapath.
- Drives every memory, register-file, PC, ALU, condition-code and LDI-temp strobe/select.
- Sits beside the datapath inside the PUnC top level.

Parameters:
- none; all encodings live in the shared package.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ir  in  16  instruction register contents
- n  in  1  negative condition code
- z  in  1  zero condition code
- p  in  1  positive condition code
- mem_w_en  out  1  memory write strobe
- mem_w_addr_sel  out  2  write addr: 0 PC+sext9, 1 base+sext6, 2 mem data
- mem_w_data_sel  out  1  write data: 0 rf_r0, 1 mem data
- mem_r_addr_sel  out  2  read addr: 0 PC, 1 PC+sext9, 2 rf_r0+sext6, 3 ldi temp
- rf_w_en  out  1  register-file write strobe
- rf_r0_addr_sel  out  1  0 ir[8:6], 1 ir[11:9]
- rf_r1_addr_sel  out  1  0 ir[2:0], 1 ir[8:6]
- rf_w_data_sel  out  2  0 ALU, 1 mem, 2 PC, 3 PC+sext9
- rf_w_addr_sel  out  1  0 ir[11:9], 1 R7
- ir_ld  out  1  load IR from memory
- pc_ld  out  1  load PC
- pc_clr  out  1  clear PC
- pc_inc  out  1  increment PC
- pc_ld_data_sel  out  2  0 PC+sext9, 1 rf_r0, 2 PC+sext11
- alu_sel  out  3  0 ADD, 1 ADDI, 2 NOT, 3 AND, 4 ANDI, 5 PASS
- cond_ld  out  1  load n/z/p
- cond_ld_data_sel  out  1  0 ALU out, 1 rf write data
- ldi_reg_ld  out  1  load LDI/STI indirection temp
- halted  out  1  high while in HALT

Behaviour:
- Reset: state <= INIT. Outputs are combinational from state+ir:
  - pc_clr=1 while rst=1 and in INIT.
  - All strobes 0 in reset; all selects 0.
- INIT (1 cycle): pc_clr=1 -> FETCH.
- FETCH: mem_r_addr_sel=PC, ir_ld=1, pc_inc=1 -> DECODE.
- DECODE: no strobes (IR settles); opcode=ir[15:12] -> EXECUTE.
- EXECUTE: strobes asserted for exactly one cycle, then -> FETCH unless noted.
  - ADD 0001 / AND 0101: alu_sel=ADDI/ANDI if ir[5] else ADD/AND; rf_w_en; cond_ld (ALU).
  - NOT 1001: alu_sel NOT; rf_w_en; cond_ld.
  - BR 0000: pc_ld (sel 0) iff (ir[11]&n)|(ir[10]&z)|(ir[9]&p); nzp=000 never branches.
  - JMP/RET 1100: pc_ld, sel 1, rf_r0_addr_sel 0.
  - JSR/JSRR 0100: rf_w_en, w_addr R7, w_data PC; pc_ld sel 2 if ir[11] else sel 1; same cycle (RF write uses pre-update PC).
  - LD 0010: r_addr 1, rf_w_en from mem, cond_ld (RF data).
  - LDR 0110: r_addr 2, rf_w_en from mem, cond_ld (RF data).
  - LEA 1110: rf_w_data 3, rf_w_en, cond_ld (RF data).
  - ST 0011: mem_w_en, w_addr 0, w_data rf_r0, rf_r0_addr_sel 1.
  - STR 0111: mem_w_en, w_addr 1, w_data rf_r0, rf_r0_addr_sel 1, rf_r1_addr_sel 1.
  - LDI 1010 / STI 1011: r_addr 1, ldi_reg_ld -> EXECUTE2.
  - HALT 1111 (TRAP) -> HALT.
  - 1000, 1101: NOP unless optional feature enabled.
- EXECUTE2:
  - LDI: r_addr 3, rf_w_en from mem, cond_ld (RF data).
  - STI: mem_w_en, w_addr 2 (mem data at r_addr 3), rf_r0_addr_sel 1.
  - -> FETCH.
- HALT: halted=1, no strobes; leaves only on rst.
- rst in any state, including mid-LDI/STI: next state INIT; no strobe asserted that cycle.
- Instruction latency: 3 cycles; LDI/STI 4 cycles.

Optional Feature:
- PUNC_CTRL_ILLEGAL_TRAP_EN:
  - When defined: opcodes 1000 and 1101 enter HALT and set a sticky illegal output (1-bit port `illegal`, cleared only by rst).
  - When undefined: those opcodes are single-cycle NOPs and the port is absent.

Decomposition:
- Package punc_ctrl_pkg: opcode constants, state encoding (INIT, FETCH, DECODE, EXECUTE, EXECUTE2, HALT), all select/ALU encodings above.
- One sub-module, punc_branch_eval: combinational nzp match of ir[11:9] vs n/z/p.

Test Plan:
- rst=1 for 2 cycles, then release -> pc_clr=1 in INIT; ir_ld=1, pc_inc=1, mem_r_addr_sel=0 next cycle.
- ir=0x1283 (ADD R1,R2,R3) -> in EXECUTE: alu_sel=0, rf_w_en=1, rf_w_addr_sel=0, cond_ld=1, cond_ld_data_sel=0; back in FETCH after 3 cycles.
- ir=0x0405 (BRz +5):
  - z=1 -> pc_ld=1, pc_ld_data_sel=0.
  - z=0,p=1 -> pc_ld=0.
- ir=0xA203 (LDI R1) -> EXECUTE: ldi_reg_ld=1, mem_r_addr_sel=1; EXECUTE2: mem_r_addr_sel=3, rf_w_en=1, rf_w_data_sel=1, cond_ld=1.
- ir=0x4802 (JSR +2) -> single cycle: rf_w_en=1, rf_w_addr_sel=1, rf_w_data_sel=2, pc_ld=1, pc_ld_data_sel=2.
- ir=0xF025 (HALT) -> halted=1 held 20 cycles with all strobes 0; rst -> INIT, halted=0.
